// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, registered borrow,
// LSB-first shifting, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d, done_q, done_d;
  logic             a_bit, b_bit, d_bit, br_next;

  always_comb begin
    a_bit   = a_q[0];
    b_bit   = b_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          br_d    = bin;
          amsb_d  = in_a[WIDTH-1];
          bmsb_d  = in_b[WIDTH-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Counter reaching WIDTH means all bits are in res_q; this edge commits.
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_q;
          bout_d  = br_q;
          ovf_d   = (amsb_q != bmsb_q) && (res_q[WIDTH-1] != amsb_q);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          a_d   = {1'b0, a_q[WIDTH-1:1]};
          b_d   = {1'b0, b_q[WIDTH-1:1]};
          res_d = {d_bit, res_q[WIDTH-1:1]};
          br_d  = br_next;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
